// File: rtl/mux_4to1_rr_arbiter_pkg.sv
// Shared types, constants and the round-robin pick helper for the 4-way arbiter.
// Every file of the arbiter imports this package.
package mux_4to1_rr_arbiter_pkg;

  localparam int REQ_N     = 4;
  localparam int SEL_WIDTH = 2;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  typedef enum logic [0:0] {
    EMPTY = ST_EMPTY,
    FULL  = ST_FULL
  } state_e;

  typedef logic [SEL_WIDTH-1:0] sel_t;

  // First set bit of req, scanning ptr, ptr+1, ... modulo REQ_N.
  // The scan runs from the far end back so that the nearest hit is written last.
  function automatic sel_t rr_pick(input logic [REQ_N-1:0] req, input sel_t ptr);
    sel_t idx;
    rr_pick = ptr;
    for (int k = REQ_N - 1; k >= 0; k--) begin
      idx = ptr + SEL_WIDTH'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux_4to1_rr_arbiter_if.sv
// Request and output bus of the 4-way round-robin arbiter.
// A word moves on an edge where its valid and ready are both high; valid never waits on ready.
interface mux_4to1_rr_arbiter_if
  import mux_4to1_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) ();

  logic [REQ_N-1:0]     req_valid;
  logic [WIDTH-1:0]     data0;
  logic [WIDTH-1:0]     data1;
  logic [WIDTH-1:0]     data2;
  logic [WIDTH-1:0]     data3;
  logic [REQ_N-1:0]     req_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_WIDTH-1:0] out_sel;
  logic                 out_ready;

  modport master (
    output req_valid, data0, data1, data2, data3, out_ready,
    input  req_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  req_valid, data0, data1, data2, data3, out_ready,
    output req_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/mux_4to1_rr_arbiter_sel_core.sv
// Combinational 4:1 word select driven by the arbiter's grant index.
module mux_4to1_16bit_sel_core
  import mux_4to1_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  sel_t             sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = d0_i;
    case (sel_i)
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      2'd3:    y_o = d3_i;
      default: y_o = d0_i;
    endcase
  end

endmodule

// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter over four requesters with bounded bursts, feeding a
// single-entry registered output stage.
module mux_4to1_rr_arbiter
  import mux_4to1_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int BURST_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mux_4to1_rr_arbiter_if.slave   bus,
  output state_e                 dbg_state_o,
  output logic [3:0]             dbg_burst_cnt_o
);

  localparam logic [3:0] BURST_MAX_C = 4'(BURST_MAX);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  sel_t             out_sel_q, out_sel_d;
  sel_t             rr_ptr_q, rr_ptr_d;
  sel_t             owner_q, owner_d;
  logic [3:0]       burst_cnt_q, burst_cnt_d;

  logic [REQ_N-1:0] req_valid;
  logic             out_valid;
  logic             any_req;
  logic             load_en;
  logic             do_load;
  logic             burst_active;
  logic             owner_valid;
  logic             burst_cont;
  logic             owner_drop;
  sel_t             scan_ptr;
  sel_t             grant;
  logic [WIDTH-1:0] sel_word;

  assign req_valid    = bus.req_valid;
  assign out_valid    = (state_q == ST_FULL);
  assign any_req      = |req_valid;
  assign load_en      = !out_valid || bus.out_ready;
  assign do_load      = load_en && any_req;

  // A non-zero beat count is what marks a burst as live; it is cleared only by an idle load.
  assign burst_active = (burst_cnt_q != 4'd0);
  assign owner_valid  = req_valid[owner_q];
  assign burst_cont   = burst_active && owner_valid && (burst_cnt_q < BURST_MAX_C);
  assign owner_drop   = burst_active && !owner_valid;

  // Once a burst has run, the search restarts just past its owner, whether it ended by count or by drop.
  assign scan_ptr     = burst_active ? sel_t'(owner_q + 1'b1) : rr_ptr_q;
  assign grant        = burst_cont ? owner_q : rr_pick(req_valid, scan_ptr);

  mux_4to1_16bit_sel_core #(.WIDTH(WIDTH)) u_sel_core (
    .sel_i (grant),
    .d0_i  (bus.data0),
    .d1_i  (bus.data1),
    .d2_i  (bus.data2),
    .d3_i  (bus.data3),
    .y_o   (sel_word)
  );

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (load_en) begin
      if (any_req) begin
        state_d    = ST_FULL;
        out_data_d = sel_word;
        out_sel_d  = grant;
        if (burst_cont) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end else begin
          owner_d     = grant;
          burst_cnt_d = 4'd1;
        end
        if ((burst_cnt_d == BURST_MAX_C) || owner_drop) rr_ptr_d = sel_t'(grant + 1'b1);
      end else begin
        state_d     = ST_EMPTY;
        burst_cnt_d = 4'd0;
        if (burst_active) rr_ptr_d = sel_t'(owner_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Reset gates the acknowledge so nothing is consumed while the stage is being cleared.
  assign bus.req_ready    = (do_load && rst_n) ? (REQ_N'(1) << grant) : '0;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_data_q;
  assign bus.out_sel      = out_sel_q;
  assign dbg_state_o      = state_e'(state_q);
  assign dbg_burst_cnt_o  = burst_cnt_q;

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Bench for the round-robin arbiter: two instances (burst limit 4 and 1) share
// the same stimulus and are each compared with a behavioural grant model.
module tb_mux_4to1_rr_arbiter;
  import mux_4to1_rr_arbiter_pkg::*;

  localparam int W   = 16;
  localparam int EW  = W + SEL_WIDTH;
  localparam int BM0 = 4;
  localparam int BM1 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]   req_valid;
  logic [W-1:0] data [4];
  logic         out_ready;

  mux_4to1_rr_arbiter_if #(.WIDTH(W)) bus0 ();
  mux_4to1_rr_arbiter_if #(.WIDTH(W)) bus1 ();

  assign bus0.req_valid = req_valid;
  assign bus0.data0     = data[0];
  assign bus0.data1     = data[1];
  assign bus0.data2     = data[2];
  assign bus0.data3     = data[3];
  assign bus0.out_ready = out_ready;
  assign bus1.req_valid = req_valid;
  assign bus1.data0     = data[0];
  assign bus1.data1     = data[1];
  assign bus1.data2     = data[2];
  assign bus1.data3     = data[3];
  assign bus1.out_ready = out_ready;

  state_e     st0, st1;
  logic [3:0] bc0, bc1;

  mux_4to1_rr_arbiter #(.WIDTH(W), .BURST_MAX(BM0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
    .dbg_state_o(st0), .dbg_burst_cnt_o(bc0)
  );

  mux_4to1_rr_arbiter #(.WIDTH(W), .BURST_MAX(BM1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
    .dbg_state_o(st1), .dbg_burst_cnt_o(bc1)
  );

  // ---------------- scoreboard / model state ----------------
  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  int            acc0[$];
  int            acc1[$];

  int m_owner [2];
  int m_beats [2];
  int m_ptr   [2];
  bit m_full  [2];
  int bmax    [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_owner[u] = 0;
      m_beats[u] = 0;
      m_ptr[u]   = 0;
      m_full[u]  = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
    acc0.delete();
    acc1.delete();
  endtask

  // Who gets the beat: the burst owner while it keeps asking and is under its
  // limit, otherwise the first asker walking round the ring from the start point.
  function automatic int model_grant(input int u, input logic [3:0] req);
    int start;
    if (m_beats[u] > 0 && req[m_owner[u]] && m_beats[u] < bmax[u]) return m_owner[u];
    start = (m_beats[u] > 0) ? (m_owner[u] + 1) % 4 : m_ptr[u];
    for (int k = 0; k < 4; k++)
      if (req[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic cycle_check(input int u);
    logic          ov;
    logic [3:0]    rr;
    logic [W-1:0]  od;
    logic [1:0]    os;
    logic [3:0]    bc;
    state_e        st;
    logic [EW-1:0] e;
    logic [3:0]    exp_rr;
    bit            load, cont, drop;
    int            g;
    if (u == 0) begin
      ov = bus0.out_valid; rr = bus0.req_ready; od = bus0.out_data; os = bus0.out_sel; bc = bc0; st = st0;
    end else begin
      ov = bus1.out_valid; rr = bus1.req_ready; od = bus1.out_data; os = bus1.out_sel; bc = bc1; st = st1;
    end
    check_eq($sformatf("out_valid%0d", u), ov, m_full[u]);
    check_eq($sformatf("state%0d", u), st, m_full[u]);
    check_eq($sformatf("burst_cnt%0d", u), bc, m_beats[u]);
    check_eq($sformatf("burst_le_max%0d", u), (32'(bc) <= bmax[u]), 1);
    if (ov && out_ready) begin
      if ((u == 0 && exp_q0.size() == 0) || (u == 1 && exp_q1.size() == 0)) begin
        check_eq($sformatf("sb_empty%0d", u), 1, 0);
      end else begin
        e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check_eq($sformatf("out_word%0d", u), {os, od}, e);
      end
      if (u == 0) acc0.push_back(int'(os));
      else        acc1.push_back(int'(os));
    end
    load   = !m_full[u] || out_ready;
    g      = model_grant(u, req_valid);
    exp_rr = (load && g >= 0) ? 4'(1 << g) : 4'b0;
    check_eq($sformatf("req_ready%0d", u), rr, exp_rr);
    if (load) begin
      if (g >= 0) begin
        cont = m_beats[u] > 0 && req_valid[m_owner[u]] && m_beats[u] < bmax[u];
        drop = m_beats[u] > 0 && !req_valid[m_owner[u]];
        e    = {g[1:0], data[g]};
        if (u == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        if (cont) m_beats[u]++;
        else begin
          m_owner[u] = g;
          m_beats[u] = 1;
        end
        if (m_beats[u] == bmax[u] || drop) m_ptr[u] = (g + 1) % 4;
        m_full[u] = 1'b1;
      end else begin
        if (m_beats[u] > 0) m_ptr[u] = (m_owner[u] + 1) % 4;
        m_beats[u] = 0;
        m_full[u]  = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    for (int i = 0; i < 4; i++) data[i] = W'($urandom);
    @(negedge clk);
    cycle_check(0);
    cycle_check(1);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] rv, input logic rdy, input int n);
    req_valid = rv;
    out_ready = rdy;
    repeat (n) tick();
  endtask

  // Reset asserted between edges: the output stage must empty at once.
  task automatic apply_reset();
    req_valid = 4'hF;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_eq("rst_valid0", bus0.out_valid, 0);
    check_eq("rst_valid1", bus1.out_valid, 0);
    check_eq("rst_sel0", bus0.out_sel, 0);
    check_eq("rst_data0", bus0.out_data, 0);
    check_eq("rst_ready0", bus0.req_ready, 0);
    check_eq("rst_ready1", bus1.req_ready, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Compare the first n accepted out_sel values with 2-bit fields of seq (field 0 first).
  task automatic check_seq(input string tag, input int u, input int n, input logic [31:0] seq);
    int got;
    for (int k = 0; k < n; k++) begin
      if ((u == 0 && acc0.size() <= k) || (u == 1 && acc1.size() <= k)) begin
        check_eq($sformatf("%s_len", tag), k, n);
        break;
      end
      got = (u == 0) ? acc0[k] : acc1[k];
      check_eq($sformatf("%s[%0d]", tag, k), got, 32'(seq[2*k +: 2]));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bmax[0]   = BM0;
    bmax[1]   = BM1;
    rst_n     = 1'b0;
    req_valid = 4'h0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) data[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'hF;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("init_valid", bus0.out_valid, 0);
    check_eq("init_sel", bus0.out_sel, 0);
    check_eq("init_data", bus0.out_data, 0);
    check_eq("init_ready0", bus0.req_ready, 0);
    check_eq("init_ready1", bus1.req_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All four asking, drain always ready: limit-1 instance rotates every beat.
    drive(4'hF, 1'b1, 7);
    check_seq("rr_seq", 1, 5, 32'h0000_00E4);

    // Two requesters, limit 4: four beats each before the pointer moves.
    apply_reset();
    drive(4'b0011, 1'b1, 11);
    check_seq("burst_seq", 0, 9, 32'h0000_5500);

    // Requester 2 bursts twice then drops; 3 and 0 are asking.
    apply_reset();
    drive(4'b0100, 1'b1, 2);
    drive(4'b1001, 1'b1, 1);
    drive(4'b0001, 1'b1, 1);
    drive(4'b0000, 1'b1, 2);
    check_seq("drop_seq", 0, 4, 32'h0000_003A);

    // Backpressure: downstream stalls for five cycles with everyone asking.
    drive(4'hF, 1'b1, 2);
    drive(4'hF, 1'b0, 5);
    drive(4'hF, 1'b1, 3);
    drive(4'h0, 1'b1, 3);

    // Idle gap: single beat from 1, then a gap, then 0, 1 and 3 ask (scan starts at 2).
    apply_reset();
    drive(4'b0010, 1'b1, 1);
    drive(4'b0000, 1'b1, 3);
    drive(4'b1011, 1'b1, 1);
    drive(4'b0000, 1'b1, 2);
    check_seq("idle_seq", 0, 2, 32'h0000_000D);

    // Random traffic with random backpressure and one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) apply_reset();
      if ($urandom_range(0, 3) != 0) req_valid = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    drive(4'h0, 1'b1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_4to1_rr_arbiter.md
Name: mux_4to1_rr_arbiter

Overview:
- Round-robin arbiter that shares a 4-input, 16-bit selection datapath between four valid/ready requesters.
- Picks one requester per beat and drives the mux select internally.
- Registers the selected word into a single-entry output stage with valid/ready to the downstream consumer.
- Supports bounded bursts: a winning requester may keep the grant for up to BURST_MAX consecutive beats.

Parameters:
- WIDTH, 16, data width of each requester and of the output.
- SEL_WIDTH, 2, select/grant index width (fixed for 4 requesters).
- BURST_MAX, 4, maximum consecutive beats granted to one requester before the pointer is forced to rotate; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  4  per-requester valid; bit i belongs to data_i.
- data0  input  WIDTH  requester 0 payload.
- data1  input  WIDTH  requester 1 payload.
- data2  input  WIDTH  requester 2 payload.
- data3  input  WIDTH  requester 3 payload.
- req_ready  output  4  one-hot or zero; bit i high means data_i is consumed this cycle.
- out_valid  output  1  output register holds a valid word.
- out_data  output  WIDTH  registered selected word.
- out_sel  output  SEL_WIDTH  index of the requester that produced out_data.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0.
  - rr_ptr=0, owner=0, burst_cnt=0, state=EMPTY.
  - req_ready is 0 while rst_n=0.
- Load condition: load_en = !out_valid || out_ready. This gives full throughput of 1 beat per cycle with no bubble on back-to-back traffic.
- Grant computation (combinational):
  - Burst continuation: if state=FULL or a burst is active, owner is valid, req_valid[owner]=1 and burst_cnt<BURST_MAX, then grant=owner.
  - Otherwise: grant = first set bit of req_valid, scanning cyclically from rr_ptr (rr_ptr, rr_ptr+1, ... mod 4).
- req_ready[i] = load_en && any(req_valid) && grant==i. It is never asserted for a requester whose valid is low.
- On a load with any(req_valid)=1:
  - out_data <= data[grant]; out_sel <= grant; out_valid <= 1.
  - If grant==owner and this is a burst continuation, burst_cnt <= burst_cnt+1. Otherwise owner <= grant and burst_cnt <= 1.
  - rr_ptr <= grant+1 (2-bit wrap, 3 -> 0) when the burst ends: burst_cnt reaches BURST_MAX on this beat, or the owner drops req_valid.
- On a load with req_valid=0:
  - out_valid <= 0; out_data and out_sel hold.
  - burst_cnt <= 0, which ends the burst.
  - rr_ptr <= owner+1 if a burst was active.
- When out_valid=1 and out_ready=0 (stall): all outputs and state hold, req_ready=0.
- State machine:
  - EMPTY -> FULL on a load with a request.
  - FULL -> FULL on out_ready with a request.
  - FULL -> EMPTY on out_ready with no request.
  - FULL stays FULL on a stall.
- Owner drops valid mid-burst: the burst terminates that cycle and the grant moves cyclically from owner+1.
- Input data is sampled only on cycles where req_ready is high. Changes while ready is low have no effect.
- Reset mid-transfer: the pending output word is discarded and out_valid drops immediately; no requester is acknowledged.
- Output stability: out_valid, out_data and out_sel are driven only from registers (no combinational path from req_valid or data to outputs). req_ready depends combinationally on out_ready and req_valid.

Decomposition:
- Shared package holds:
  - REQ_N=4.
  - SEL_WIDTH=2.
  - state enum {EMPTY, FULL}.
  - function rr_pick(req[3:0], ptr[1:0]) returning the grant index.
- One sub-module is natural: mux_4to1_16bit_sel_core, the combinational 4:1 WIDTH-bit select on the grant index, instantiated once.

Test Plan:
- Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_sel=0, req_ready=0 within the same cycle. After release, the first grant goes to the lowest valid index from ptr=0.
- Round-robin, BURST_MAX=1, all four valid, out_ready=1 -> out_sel sequence 0,1,2,3,0; out_data=data_i on each beat; one req_ready bit per cycle.
- Burst, BURST_MAX=4, req_valid=4'b0011, out_ready=1 -> sel 0,0,0,0,1,1,1,1,0; burst_cnt never exceeds 4.
- Owner drop: requester 2 owns a burst after 2 beats, then req_valid[2]=0 while 3 and 0 are valid -> next grant=3, then 0.
- Backpressure: out_ready=0 for 5 cycles with all requests valid -> out_data, out_sel held and req_ready=0 throughout. On the first out_ready=1 there is exactly one ready pulse and no data is lost.
- Idle gap: a single beat from requester 1 then req_valid=0 -> out_valid falls one cycle after acceptance, and the next single request from 1 is granted after 2 and 3 are checked (ptr=2).
